// File: rtl/bp_be_pkg.sv
// Shared back-end definitions: the FE queue packet layout and its width.
package bp_be_pkg;

  // Packet handed from the front end to the back end.
  typedef struct packed {
    logic [1:0]  msg_type;
    logic [38:0] pc;
    logic [31:0] instr;
  } bp_fe_queue_s;

  localparam int fe_queue_width_lp = $bits(bp_fe_queue_s);

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bp_be_fe_queue_ptr.sv
// Circular pointer with a wrap bit. The wrap bit is the MSB of a ptr_w+1 bit
// counter, so a plain increment rolls the index modulo els_p and toggles wrap.
module bp_be_fe_queue_ptr #(
  parameter  int els_p     = 8,
  localparam int ptr_w_lp  = $clog2(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                inc_i,
  output logic [ptr_w_lp-1:0] ptr_o,
  output logic                wrap_o
);

  logic [ptr_w_lp:0] ptr_q, ptr_d;

  // Next pointer: advance by one on increment.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + (ptr_w_lp+1)'(1);
  end

  // Pointer register; reset and flush both return to slot 0, wrap 0.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) ptr_q <= '0;
    else                    ptr_q <= ptr_d;
  end

  assign ptr_o  = ptr_q[ptr_w_lp-1:0];
  assign wrap_o = ptr_q[ptr_w_lp];

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// FE-to-BE packet FIFO with single-cycle flush and occupancy reporting.
// Ready never looks at valid, and a full buffer refuses even when the head is
// leaving in the same cycle, keeping ready off any long combinational path.
module bp_be_fe_queue_buffer
  import bp_be_pkg::*;
#(
  parameter  int els_p    = 8,
  parameter  int width_p  = fe_queue_width_lp,
  parameter  int hwm_p    = 6,
  localparam int ptr_w_lp = $clog2(els_p),
  localparam int cnt_w_lp = $clog2(els_p+1)
) (
  input  logic                clk_i,
  input  logic                reset_i,

  input  logic [width_p-1:0]  fe_queue_i,
  input  logic                fe_queue_v_i,
  output logic                fe_queue_ready_and_o,

  output logic [width_p-1:0]  fe_queue_o,
  output logic                fe_queue_v_o,
  input  logic                fe_queue_ready_and_i,

  input  logic                clear_i,
  output logic [cnt_w_lp-1:0] count_o,
  output logic                almost_full_o,
  output logic                empty_o
);

  logic [els_p-1:0][width_p-1:0] mem_q;
  logic [ptr_w_lp-1:0]           wptr, rptr;
  logic                          wwrap, rwrap;
  logic [cnt_w_lp-1:0]           count_q, count_d;
  logic                          full, empty, enq, deq;

  bp_be_fe_queue_ptr #(.els_p(els_p)) u_wptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .inc_i   (enq),
    .ptr_o   (wptr),
    .wrap_o  (wwrap)
  );

  bp_be_fe_queue_ptr #(.els_p(els_p)) u_rptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .inc_i   (deq),
    .ptr_o   (rptr),
    .wrap_o  (rwrap)
  );

  assign full  = (wptr == rptr) && (wwrap != rwrap);
  assign empty = (wptr == rptr) && (wwrap == rwrap);

  assign fe_queue_ready_and_o = ~full & ~clear_i & ~reset_i;
  assign fe_queue_v_o         = ~empty & ~clear_i;
  assign fe_queue_o           = mem_q[rptr];

  assign enq = fe_queue_v_i & fe_queue_ready_and_o;
  assign deq = fe_queue_v_o & fe_queue_ready_and_i;

  // Packet storage; contents survive reset and flush, only pointers move.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr] <= fe_queue_i;
  end

  // Occupancy next-state: up on enq alone, down on deq alone.
  always_comb begin
    count_d = count_q;
    if (enq && !deq)      count_d = count_q + cnt_w_lp'(1);
    else if (deq && !enq) count_d = count_q - cnt_w_lp'(1);
  end

  // Occupancy register.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) count_q <= '0;
    else                    count_q <= count_d;
  end

  assign count_o       = count_q;
  assign almost_full_o = (count_q >= cnt_w_lp'(hwm_p));
  assign empty_o       = (count_q == '0);

`ifndef SYNTHESIS
  // Simulation sanity: clean handshake inputs, legal parameters, bounded count.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!$isunknown(fe_queue_v_i))         else $error("fe_queue_v_i is X");
      assert (!$isunknown(fe_queue_ready_and_i)) else $error("fe_queue_ready_and_i is X");
      assert (is_pow2(els_p))                    else $error("els_p not a power of two");
      assert (hwm_p >= 1 && hwm_p <= els_p)      else $error("hwm_p out of range");
      assert (count_q <= cnt_w_lp'(els_p))       else $error("count overflow");
    end
  end
`endif

endmodule

// File: doc/bp_be_fe_queue_buffer.md
Name: bp_be_fe_queue_buffer

Overview:
- Circular FIFO between the front-end fetch stage and the back-end top.
- Buffers FE queue packets (fetched instructions and exceptions) and presents them to the back end with a valid/ready-and handshake.
- A single-cycle flush drops all buffered packets when the back end redirects the front end through an FE command (for example, a mispredict or trap).
- Also reports occupancy, so the front end can throttle itself.

Parameters:
- els_p, 8: number of entries; must be a power of two, at least 2.
- width_p, fe_queue_width_lp: packet width in bits, taken from the bp_fe_queue_s struct.
- hwm_p, 6: high-water mark. almost_full_o asserts when count is at least hwm_p. Range 1..els_p.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- fe_queue_i  in  width_p  packet from the FE.
- fe_queue_v_i  in  1  FE packet valid.
- fe_queue_ready_and_o  out  1  buffer can accept a packet this cycle.
- fe_queue_o  out  width_p  head packet to the BE.
- fe_queue_v_o  out  1  head packet valid.
- fe_queue_ready_and_i  in  1  BE ready to take the head packet.
- clear_i  in  1  flush all entries (FE command redirect).
- count_o  out  $clog2(els_p+1)  current occupancy.
- almost_full_o  out  1  count_o >= hwm_p.
- empty_o  out  1  count_o == 0.

Behaviour:
- Storage:
  - els_p x width_p register array.
  - Write and read pointers are ptr_w = $clog2(els_p) bits, each with an extra wrap bit.
  - full when the pointers are equal and the wrap bits differ; empty when pointers and wrap bits are both equal.
- Handshakes:
  - enq = fe_queue_v_i & fe_queue_ready_and_o.
  - deq = fe_queue_v_o & fe_queue_ready_and_i.
- fe_queue_ready_and_o = ~full & ~clear_i & ~reset_i.
  - It does not depend on fe_queue_v_i (no valid-to-ready path).
  - There is no accept-when-full-with-simultaneous-dequeue.
- fe_queue_v_o = ~empty & ~clear_i.
  - fe_queue_o is a combinational read of the array at the read pointer; the value is don't-care while v_o = 0.
- Latency: a packet enqueued in cycle N is visible at the head in cycle N+1 at the earliest. There is no bypass when empty.
- Order: strict FIFO.
  - Enqueue writes the array at the write pointer, then increments the write pointer.
  - Dequeue increments the read pointer.
  - Pointers wrap modulo els_p, toggling the wrap bit.
- Simultaneous enq and deq (neither full nor empty): both pointers advance and count is unchanged.
- count register:
  - +1 on enq only, -1 on deq only, unchanged on both or neither.
  - It is never permitted to exceed els_p or go below 0; the bench asserts this.
- clear_i (synchronous):
  - Next cycle, both pointers and wrap bits are 0 and count is 0.
  - Any enq or deq in the same cycle is ignored; the handshakes above already gate them.
  - Array contents are not cleared.
  - clear_i held for several cycles keeps the buffer empty and not ready.
- Reset, including mid-operation:
  - Pointers, wrap bits and count become 0.
  - Outputs next cycle: fe_queue_v_o = 0, fe_queue_ready_and_o = 1 (once reset deasserts), count_o = 0, empty_o = 1, almost_full_o = 0.
  - While reset_i is high, fe_queue_ready_and_o = 0.
  - Array contents are not reset.
- almost_full_o and empty_o are derived from the registered count, so they carry no combinational input dependence.
- No state machine beyond the pointer and count registers.
- Assertions in simulation:
  - no X on fe_queue_v_i / fe_queue_ready_and_i outside reset;
  - els_p is a power of two;
  - hwm_p <= els_p.

Decomposition:
- Shared package (bp_be_pkg): the bp_fe_queue_s width macro already supplies width_p. No new typedefs are needed.
- The pointer/wrap logic is naturally one sub-module, bp_be_fe_queue_ptr: a circular pointer with a wrap bit, an increment, and a synchronous clear. It is instantiated twice (read and write).
- Full/empty, count and the handshakes stay in the top.

Test Plan:
- Reset then idle:
  - after reset_i drops → fe_queue_ready_and_o = 1, fe_queue_v_o = 0, count_o = 0, empty_o = 1.
  - same result with reset asserted after 3 enqueues: count_o = 0 and fe_queue_v_o = 0 the next cycle.
- Fill, no dequeue: enqueue packets 0x1..0x8 (els_p = 8) with ready_and_i = 0.
  - almost_full_o rises after the 6th enqueue.
  - After the 8th: count_o = 8, ready_and_o = 0.
  - A 9th valid is not accepted.
- Drain: from full, hold ready_and_i = 1.
  - Head reads 0x1..0x8 in order, one per cycle.
  - empty_o = 1 and v_o = 0 after the 8th.
- Streaming: v_i = 1 and ready_and_i = 1 for 20 cycles with incrementing data.
  - After the first cycle, count_o stays 1.
  - Output equals input delayed one cycle.
  - Pointers wrap at least twice with no loss or duplication.
- Flush: with 5 entries, assert clear_i together with fe_queue_v_i = 1 and ready_and_i = 1.
  - Same cycle: ready_and_o = 0, v_o = 0.
  - Next cycle: count_o = 0, empty_o = 1.
  - The next enqueue of 0xA appears at the head one cycle later.
- Random backpressure: 1000 cycles with random v_i, ready_and_i, and 2% clear_i, compared against a scoreboard model.
  - No reordering.
  - count_o always matches the model.
  - count_o never exceeds els_p.
